// File: rtl/branch_exec_queue_if.sv
// Handshake and result bus between the branch RS, the branch execution queue and the CDB arbiter.
// master = RS/CDB side, slave = branch_exec_queue.
interface branch_exec_queue_if #(
    parameter int XLEN        = 32,
    parameter int PRF_LEN     = 6,
    parameter int ROB_LEN     = 5,
    parameter int QUEUE_DEPTH = 4
);
    localparam int CW = $clog2(QUEUE_DEPTH) + 1;

    logic               in_valid;
    logic               in_ready;
    logic [XLEN-1:0]    in_pc;
    logic [XLEN-1:0]    in_opa;
    logic [XLEN-1:0]    in_opb;
    logic [XLEN-1:0]    in_offset;
    logic [2:0]         in_func;
    logic               in_cond_branch;
    logic               in_jalr;
    logic               in_pred_taken;
    logic [XLEN-1:0]    in_pred_target;
    logic [PRF_LEN-1:0] in_dest_preg;
    logic [ROB_LEN-1:0] in_rob_idx;
    logic               cdb_grant;
    logic               out_valid;
    logic               out_taken;
    logic [XLEN-1:0]    out_target;
    logic [XLEN-1:0]    out_link;
    logic               out_mis_pred;
    logic [PRF_LEN-1:0] out_prf_idx;
    logic [ROB_LEN-1:0] out_rob_idx;
    logic [CW-1:0]      out_count;

    modport master (
        output in_valid, in_pc, in_opa, in_opb, in_offset, in_func, in_cond_branch,
               in_jalr, in_pred_taken, in_pred_target, in_dest_preg, in_rob_idx, cdb_grant,
        input  in_ready, out_valid, out_taken, out_target, out_link, out_mis_pred,
               out_prf_idx, out_rob_idx, out_count
    );

    modport slave (
        input  in_valid, in_pc, in_opa, in_opb, in_offset, in_func, in_cond_branch,
               in_jalr, in_pred_taken, in_pred_target, in_dest_preg, in_rob_idx, cdb_grant,
        output in_ready, out_valid, out_taken, out_target, out_link, out_mis_pred,
               out_prf_idx, out_rob_idx, out_count
    );
endinterface

// File: rtl/branch_exec_queue.sv
// Branch execution unit: resolves B-type/JAL/JALR and buffers results in a FIFO until CDB grant.
// Optional macro BR_STATS_EN adds resolved/mispredict counters (stat_resolved, stat_mispred).
module branch_exec_queue #(
    parameter int XLEN        = 32,
    parameter int PRF_LEN     = 6,
    parameter int ROB_LEN     = 5,
    parameter int QUEUE_DEPTH = 4
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  flush,
    branch_exec_queue_if.slave    bq
`ifdef BR_STATS_EN
    ,
    output logic [31:0]           stat_resolved,
    output logic [31:0]           stat_mispred
`endif
);
    localparam int PW = $clog2(QUEUE_DEPTH);
    localparam int CW = PW + 1;

    typedef struct packed {
        logic               taken;
        logic [XLEN-1:0]    target;
        logic [XLEN-1:0]    link;
        logic               mis_pred;
        logic [PRF_LEN-1:0] prf;
        logic [ROB_LEN-1:0] rob;
    } entry_t;

    entry_t          mem [QUEUE_DEPTH];
    entry_t          res;
    entry_t          next_head_entry;
    entry_t          out_q;
    logic [PW-1:0]   head;
    logic [PW-1:0]   tail;
    logic [PW-1:0]   head_n;
    logic [CW-1:0]   count;
    logic [CW-1:0]   count_n;
    logic            cond;
    logic            taken;
    logic [XLEN-1:0] target;
    logic [XLEN-1:0] jalr_sum;
    logic            push;
    logic            pop;

    always_comb begin
        cond = 1'b0;
        case (bq.in_func)
            3'b000:  cond = (bq.in_opa == bq.in_opb);
            3'b001:  cond = (bq.in_opa != bq.in_opb);
            3'b100:  cond = ($signed(bq.in_opa) < $signed(bq.in_opb));
            3'b101:  cond = ($signed(bq.in_opa) >= $signed(bq.in_opb));
            3'b110:  cond = (bq.in_opa < bq.in_opb);
            3'b111:  cond = (bq.in_opa >= bq.in_opb);
            default: cond = 1'b0;
        endcase
        taken    = bq.in_cond_branch ? cond : 1'b1;
        jalr_sum = bq.in_opa + bq.in_offset;
        if (bq.in_jalr && !bq.in_cond_branch)
            target = {jalr_sum[XLEN-1:1], 1'b0};
        else
            target = bq.in_pc + bq.in_offset;
        res.taken    = taken;
        res.target   = target;
        res.link     = bq.in_pc + XLEN'(4);
        // a not-taken prediction that holds never compares targets
        res.mis_pred = (taken != bq.in_pred_taken) || (taken && (target != bq.in_pred_target));
        res.prf      = bq.in_dest_preg;
        res.rob      = bq.in_rob_idx;
    end

    assign bq.in_ready = (count < CW'(QUEUE_DEPTH)) && !flush;
    assign push        = bq.in_valid && bq.in_ready;
    assign pop         = bq.cdb_grant && (count != '0) && !flush;
    assign head_n      = pop ? head + PW'(1) : head;

    always_comb begin
        count_n = count;
        if (push && !pop)
            count_n = count + CW'(1);
        else if (pop && !push)
            count_n = count - CW'(1);
    end

    // the entry about to become head may be the one written this very edge
    always_comb begin
        if (push && (tail == head_n))
            next_head_entry = res;
        else
            next_head_entry = mem[head_n];
    end

    always_ff @(posedge clock) begin
        if (push)
            mem[tail] <= res;
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            out_q <= '0;
        end else if (flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (push)
                tail <= tail + PW'(1);
            head  <= head_n;
            count <= count_n;
            if (count_n != '0)
                out_q <= next_head_entry;
        end
    end

    assign bq.out_valid    = (count != '0);
    assign bq.out_count    = count;
    assign bq.out_taken    = out_q.taken;
    assign bq.out_target   = out_q.target;
    assign bq.out_link     = out_q.link;
    assign bq.out_mis_pred = out_q.mis_pred;
    assign bq.out_prf_idx  = out_q.prf;
    assign bq.out_rob_idx  = out_q.rob;

`ifdef BR_STATS_EN
    always_ff @(posedge clock) begin
        if (!reset) begin
            stat_resolved <= '0;
            stat_mispred  <= '0;
        end else if (pop) begin
            stat_resolved <= stat_resolved + 32'd1;
            if (out_q.mis_pred)
                stat_mispred <= stat_mispred + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_branch_exec_queue.sv
// Directed-vector bench for branch_exec_queue: resolution, ordering, back-pressure, flush, reset.
module tb_branch_exec_queue;
    logic clock = 1'b0;
    logic reset;
    logic flush;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clock = ~clock;

    branch_exec_queue_if #(.XLEN(32), .PRF_LEN(6), .ROB_LEN(5), .QUEUE_DEPTH(4)) bq ();

`ifdef BR_STATS_EN
    logic [31:0] stat_resolved;
    logic [31:0] stat_mispred;
`endif

    branch_exec_queue #(.XLEN(32), .PRF_LEN(6), .ROB_LEN(5), .QUEUE_DEPTH(4)) dut (
        .clock         (clock),
        .reset         (reset),
        .flush         (flush),
        .bq            (bq.slave)
`ifdef BR_STATS_EN
        ,
        .stat_resolved (stat_resolved),
        .stat_mispred  (stat_mispred)
`endif
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic set_br(input logic [31:0] pc, input logic [31:0] opa, input logic [31:0] opb,
                          input logic [31:0] off, input logic [2:0] func, input logic cond_br,
                          input logic jalr, input logic pt, input logic [31:0] ptgt,
                          input logic [5:0] preg, input logic [4:0] rob);
        bq.in_valid       = 1'b1;
        bq.in_pc          = pc;
        bq.in_opa         = opa;
        bq.in_opb         = opb;
        bq.in_offset      = off;
        bq.in_func        = func;
        bq.in_cond_branch = cond_br;
        bq.in_jalr        = jalr;
        bq.in_pred_taken  = pt;
        bq.in_pred_target = ptgt;
        bq.in_dest_preg   = preg;
        bq.in_rob_idx     = rob;
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    initial begin
        reset = 1'b0;
        flush = 1'b0;
        bq.cdb_grant = 1'b0;
        set_br(32'h0, 32'h0, 32'h0, 32'h0, 3'b000, 1'b1, 1'b0, 1'b0, 32'h0, 6'd0, 5'd0);
        bq.in_valid = 1'b0;
        step();
        step();
        chk("rst_valid", 64'(bq.out_valid), 64'd0);
        chk("rst_count", 64'(bq.out_count), 64'd0);
        chk("rst_target", 64'(bq.out_target), 64'd0);
        chk("rst_ready", 64'(bq.in_ready), 64'd1);
        @(negedge clock);
        reset = 1'b1;

        // 1: BEQ taken, correctly predicted, popped next cycle
        @(negedge clock);
        set_br(32'h100, 32'd5, 32'd5, 32'h20, 3'b000, 1'b1, 1'b0, 1'b1, 32'h120, 6'd3, 5'd1);
        bq.cdb_grant = 1'b1;
        step();
        chk("beq_valid", 64'(bq.out_valid), 64'd1);
        chk("beq_taken", 64'(bq.out_taken), 64'd1);
        chk("beq_target", 64'(bq.out_target), 64'h120);
        chk("beq_link", 64'(bq.out_link), 64'h104);
        chk("beq_mis", 64'(bq.out_mis_pred), 64'd0);
        chk("beq_prf", 64'(bq.out_prf_idx), 64'd3);
        @(negedge clock);
        bq.in_valid = 1'b0;
        step();
        chk("beq_pop_valid", 64'(bq.out_valid), 64'd0);
        chk("beq_hold_target", 64'(bq.out_target), 64'h120);

        // 2: BLT vs BLTU with -1 / 1, back to back under continuous grant
        @(negedge clock);
        set_br(32'h200, 32'hFFFF_FFFF, 32'd1, 32'h40, 3'b100, 1'b1, 1'b0, 1'b1, 32'h240, 6'd4, 5'd2);
        step();
        chk("blt_taken", 64'(bq.out_taken), 64'd1);
        chk("blt_mis", 64'(bq.out_mis_pred), 64'd0);
        @(negedge clock);
        set_br(32'h200, 32'hFFFF_FFFF, 32'd1, 32'h40, 3'b110, 1'b1, 1'b0, 1'b1, 32'h240, 6'd5, 5'd3);
        step();
        chk("bltu_taken", 64'(bq.out_taken), 64'd0);
        chk("bltu_mis", 64'(bq.out_mis_pred), 64'd1);
        chk("bltu_rob", 64'(bq.out_rob_idx), 64'd3);
        chk("bltu_count", 64'(bq.out_count), 64'd1);

        // 3: JALR clears bit 0 of the sum
        @(negedge clock);
        set_br(32'h300, 32'h1003, 32'h0, 32'h10, 3'b000, 1'b0, 1'b1, 1'b1, 32'h1012, 6'd6, 5'd4);
        step();
        chk("jalr_target", 64'(bq.out_target), 64'h1012);
        chk("jalr_link", 64'(bq.out_link), 64'h304);
        chk("jalr_mis", 64'(bq.out_mis_pred), 64'd0);
        @(negedge clock);
        set_br(32'h300, 32'h1003, 32'h0, 32'h10, 3'b000, 1'b0, 1'b1, 1'b1, 32'h1013, 6'd6, 5'd5);
        step();
        chk("jalr_mis2", 64'(bq.out_mis_pred), 64'd1);

        // BNE not taken, predicted not taken with a junk target: no mispredict
        @(negedge clock);
        set_br(32'h400, 32'd7, 32'd7, 32'h80, 3'b001, 1'b1, 1'b0, 1'b0, 32'hDEAD_BEEF, 6'd7, 5'd6);
        step();
        chk("bne_taken", 64'(bq.out_taken), 64'd0);
        chk("bne_mis", 64'(bq.out_mis_pred), 64'd0);
        // reserved func 010 never takes
        @(negedge clock);
        set_br(32'h500, 32'd1, 32'd1, 32'h8, 3'b010, 1'b1, 1'b0, 1'b1, 32'h508, 6'd8, 5'd7);
        step();
        chk("f010_taken", 64'(bq.out_taken), 64'd0);
        chk("f010_mis", 64'(bq.out_mis_pred), 64'd1);
        // JAL: target pc+offset, wraps modulo 2^32
        @(negedge clock);
        set_br(32'hFFFF_FFF0, 32'h0, 32'h0, 32'h20, 3'b000, 1'b0, 1'b0, 1'b1, 32'h10, 6'd9, 5'd8);
        step();
        chk("jal_target", 64'(bq.out_target), 64'h10);
        chk("jal_link", 64'(bq.out_link), 64'hFFFF_FFF4);
        chk("jal_mis", 64'(bq.out_mis_pred), 64'd0);
        @(negedge clock);
        bq.in_valid = 1'b0;
        step();
        chk("drain_valid", 64'(bq.out_valid), 64'd0);

        // 4: fill under back-pressure, refuse a fifth, drain in order
        @(negedge clock);
        bq.cdb_grant = 1'b0;
        for (int i = 0; i < 4; i++) begin
            set_br(32'h600, 32'd1, 32'd2, 32'h4, 3'b000, 1'b1, 1'b0, 1'b0, 32'h0, 6'd10, 5'(10 + i));
            step();
            @(negedge clock);
        end
        chk("full_count", 64'(bq.out_count), 64'd4);
        chk("full_ready", 64'(bq.in_ready), 64'd0);
        set_br(32'h600, 32'd1, 32'd2, 32'h4, 3'b000, 1'b1, 1'b0, 1'b0, 32'h0, 6'd10, 5'd20);
        step();
        chk("full_no_push", 64'(bq.out_count), 64'd4);
        chk("full_head", 64'(bq.out_rob_idx), 64'd10);
        @(negedge clock);
        bq.in_valid  = 1'b0;
        bq.cdb_grant = 1'b1;
        for (int i = 1; i < 4; i++) begin
            step();
            chk("drain_order", 64'(bq.out_rob_idx), 64'(10 + i));
        end
        step();
        chk("drain_count", 64'(bq.out_count), 64'd0);
        chk("drain_empty", 64'(bq.out_valid), 64'd0);

        // 5: flush beats simultaneous push and pop
        @(negedge clock);
        bq.cdb_grant = 1'b0;
        for (int i = 0; i < 3; i++) begin
            set_br(32'h700, 32'd0, 32'd0, 32'h4, 3'b000, 1'b1, 1'b0, 1'b1, 32'h704, 6'd11, 5'(21 + i));
            step();
            @(negedge clock);
        end
        chk("pre_flush_count", 64'(bq.out_count), 64'd3);
        set_br(32'h700, 32'd0, 32'd0, 32'h4, 3'b000, 1'b1, 1'b0, 1'b1, 32'h704, 6'd11, 5'd25);
        bq.cdb_grant = 1'b1;
        flush = 1'b1;
        #1;
        chk("flush_ready", 64'(bq.in_ready), 64'd0);
        step();
        chk("flush_count", 64'(bq.out_count), 64'd0);
        chk("flush_valid", 64'(bq.out_valid), 64'd0);
        @(negedge clock);
        flush = 1'b0;
        bq.cdb_grant = 1'b0;
        set_br(32'h800, 32'd0, 32'd0, 32'h4, 3'b000, 1'b1, 1'b0, 1'b1, 32'h804, 6'd12, 5'd26);
        step();
        chk("post_flush_rob", 64'(bq.out_rob_idx), 64'd26);
        chk("post_flush_count", 64'(bq.out_count), 64'd1);

        // 6: reset while non-empty
        @(negedge clock);
        set_br(32'h900, 32'd0, 32'd0, 32'h4, 3'b000, 1'b1, 1'b0, 1'b1, 32'h904, 6'd13, 5'd27);
        step();
        chk("pre_rst_count", 64'(bq.out_count), 64'd2);
        @(negedge clock);
        bq.in_valid = 1'b0;
        reset = 1'b0;
        step();
        chk("rst2_valid", 64'(bq.out_valid), 64'd0);
        chk("rst2_count", 64'(bq.out_count), 64'd0);
        chk("rst2_rob", 64'(bq.out_rob_idx), 64'd0);
`ifdef BR_STATS_EN
        chk("rst2_stat_res", 64'(stat_resolved), 64'd0);
        chk("rst2_stat_mis", 64'(stat_mispred), 64'd0);
`endif
        @(negedge clock);
        reset = 1'b1;
        step();
        chk("rst2_after", 64'(bq.out_valid), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/branch_exec_queue.md
Name: branch_exec_queue

Overview:
Parametrised branch execution unit that supersedes the single-slot branch resolver.
- Resolves conditional branches, JAL and JALR.
- Computes taken direction, target, link value and misprediction.
- Buffers resolved results in a FIFO until the CDB arbiter grants a broadcast slot.
- Sits between the branch reservation station and the CDB/ROB. Supports back-pressure and a pipeline-wide flush.

Parameters:
XLEN, 32, operand/PC width
PRF_LEN, 6, physical register index width
ROB_LEN, 5, ROB index width
QUEUE_DEPTH, 4, result FIFO entries (power of two, >=2)

Ports:
clock  input  1  rising-edge clock
reset  input  1  synchronous, active-low; 0 at a rising clock edge resets all state
in_valid  input  1  RS presents a branch
in_ready  output  1  unit accepts a branch this cycle
in_pc  input  XLEN  branch PC
in_opa  input  XLEN  rs1 value
in_opb  input  XLEN  rs2 value
in_offset  input  XLEN  sign-extended immediate
in_func  input  3  funct3 compare code
in_cond_branch  input  1  conditional branch (B-type)
in_jalr  input  1  JALR (ignored if in_cond_branch=1)
in_pred_taken  input  1  predicted direction
in_pred_target  input  XLEN  predicted target
in_dest_preg  input  PRF_LEN  link destination preg
in_rob_idx  input  ROB_LEN  ROB tag
cdb_grant  input  1  head entry broadcast this cycle
flush  input  1  squash all buffered results
out_valid  output  1  head entry valid
out_taken  output  1  resolved direction
out_target  output  XLEN  resolved target
out_link  output  XLEN  in_pc+4
out_mis_pred  output  1  mispredict flag
out_prf_idx  output  PRF_LEN  head dest preg
out_rob_idx  output  ROB_LEN  head ROB tag
out_count  output  clog2(QUEUE_DEPTH)+1  occupancy

Behaviour:
- Reset (reset==0 at an edge): head=tail=count=0. out_valid=0 and out_count=0. All out_* data fields are 0.
- Accept: transfer when in_valid && in_ready. in_ready = (count < QUEUE_DEPTH) && !flush. No pass-through when the FIFO is full.
- Resolution is combinational on the inputs and written into the tail entry at the accept edge.
- Latency: accepted at edge N -> earliest out_valid at cycle N+1. Results leave in acceptance order.
- Condition codes (in_func):
  - 000 eq, 001 ne: compare in_opa/in_opb.
  - 100 lt, 101 ge: signed compare.
  - 110 ltu, 111 geu: unsigned compare.
  - 010 and 011: cond=0.
- Direction: taken = in_cond_branch ? cond : 1.
- Target:
  - JALR: (in_opa + in_offset) with bit 0 cleared.
  - Otherwise: in_pc + in_offset.
  - All sums modulo 2^XLEN.
- out_link = in_pc + 4, modulo 2^XLEN.
- mis_pred = (taken != in_pred_taken) || (taken && target != in_pred_target). A not-taken branch predicted not-taken never mispredicts, whatever in_pred_target holds.
- Pop: on cdb_grant && out_valid. cdb_grant with the FIFO empty is ignored.
- out_* always reflect the head entry. When empty, out_valid=0 and the data fields hold their last value.
- Simultaneous push and pop: count is unchanged and both pointers advance.
- Pointers wrap modulo QUEUE_DEPTH.
- flush: at the edge, count, head and tail go to 0. flush overrides a same-cycle push and pop. out_valid=0 in the next cycle.
- Reset while non-empty discards all entries in the same way as flush.

Optional Feature:
BR_STATS_EN:
- When defined: adds outputs stat_resolved[31:0] and stat_mispred[31:0].
  - Each increments by 1 when an entry pops (cdb_grant && out_valid && !flush); stat_mispred only if the popped head has out_mis_pred=1.
  - Both counters wrap at 2^32, are cleared by reset, and are not cleared by flush.
- When undefined: no ports, no logic.

Test Plan:
1. BEQ, opa=opb=5, pc=0x100, offset=0x20, pred_taken=1, pred_target=0x120, in_valid for 1 cycle, cdb_grant held 1 -> next cycle out_valid=1, taken=1, target=0x120, link=0x104, mis_pred=0; following cycle out_valid=0.
2. BLT, opa=0xFFFFFFFF, opb=1 -> taken=1; BLTU with the same operands -> taken=0. Both predicted taken at target pc+offset -> first mis_pred=0, second mis_pred=1.
3. JALR, opa=0x1003, offset=0x10, pred_taken=1, pred_target=0x1012 -> target=0x1012, mis_pred=0. Same with pred_target=0x1013 -> mis_pred=1.
4. cdb_grant=0, push 4 branches -> out_count=4, in_ready=0. A 5th in_valid is not accepted. Then cdb_grant=1 for 4 cycles -> ROB tags emerge in order, count returns to 0.
5. 3 entries buffered; flush with a same-cycle in_valid and cdb_grant -> next cycle count=0, out_valid=0, the new branch is dropped.
6. 2 entries buffered, reset=0 for 1 cycle -> out_valid=0, out_count=0. With BR_STATS_EN, both stats read 0 after reset.
